// File: rtl/alu_pipe_hs.sv
// Two-stage execute pipeline with valid/ready handshake on both sides and a pass-through tag.
// Stage 1 registers the operands; stage 2 registers the result and the flags of that same transaction.
module alu_pipe_hs #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned SHW   = $clog2(WIDTH),
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shift_amt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             overFlowFlag,
  output logic             signFlag,
  output logic             illegalFlag
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_ROR  = 4'd3;
  localparam logic [3:0] OP_MINU = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_MAXU = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [SHW-1:0]   s1_sh;
  logic [TAG_W-1:0] s1_tag;

  logic adv2;

  // Stage 2 may load when it is empty or being drained; stage 1 may load when it is empty or moving on.
  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     ror_v;
  logic [WIDTH-1:0]     rol_v;
  logic                 a_lt_b;
  logic                 a_slt_b;
  logic [WIDTH-1:0]     res_c;
  logic                 carry_c;
  logic                 ovf_c;
  logic                 ill_c;

  // Execute: result and flags derived only from the operands held in stage 1.
  always_comb begin
    sum     = {1'b0, s1_a} + {1'b0, s1_b};
    diff    = s1_a - s1_b;
    prod    = {{WIDTH{1'b0}}, s1_a} * {{WIDTH{1'b0}}, s1_b};
    ror_v   = (s1_a >> s1_sh) | (s1_a << (WIDTH - 32'(s1_sh)));
    rol_v   = (s1_a << s1_sh) | (s1_a >> (WIDTH - 32'(s1_sh)));
    a_lt_b  = s1_a < s1_b;
    a_slt_b = $signed(s1_a) < $signed(s1_b);
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    ill_c   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        res_c   = sum[MSB:0];
        carry_c = sum[WIDTH];
        ovf_c   = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
      end
      OP_SUB: begin
        res_c   = diff;
        carry_c = a_lt_b;
        ovf_c   = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
      end
      OP_MUL: begin
        res_c   = prod[MSB:0];
        carry_c = |prod[2*WIDTH-1:WIDTH];
      end
      OP_ROR:  res_c = ror_v;
      OP_MINU: res_c = a_lt_b ? s1_a : s1_b;
      OP_XNOR: res_c = ~(s1_a ^ s1_b);
      OP_NOR:  res_c = ~(s1_a | s1_b);
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_ROL:  res_c = rol_v;
      OP_MAXU: res_c = a_lt_b ? s1_b : s1_a;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, a_slt_b};
      default: ill_c = 1'b1;
    endcase
  end

  // Stage 1: operand capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sh    <= '0;
      s1_tag   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= opcode;
        s1_a   <= input1;
        s1_b   <= input2;
        s1_sh  <= shift_amt;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: result, flags and tag; frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      result       <= '0;
      out_tag      <= '0;
      carryFlag    <= 1'b0;
      zeroFlag     <= 1'b0;
      overFlowFlag <= 1'b0;
      signFlag     <= 1'b0;
      illegalFlag  <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result       <= res_c;
        out_tag      <= s1_tag;
        carryFlag    <= carry_c;
        zeroFlag     <= (res_c == '0);
        overFlowFlag <= ovf_c;
        signFlag     <= res_c[MSB];
        illegalFlag  <= ill_c;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe_hs.sv
// Directed bench for alu_pipe_hs: an 8-bit and a 128-bit instance share clock and reset.
module tb_alu_pipe_hs;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // 8-bit instance signals
  logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [3:0]  n_op;
  logic [7:0]  n_a, n_b, n_res;
  logic [2:0]  n_sh;
  logic [3:0]  n_tag, n_out_tag;
  logic        n_c, n_z, n_v, n_s, n_i;

  // 128-bit instance signals
  logic          w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [3:0]    w_op;
  logic [127:0]  w_a, w_b, w_res;
  logic [6:0]    w_sh;
  logic [3:0]    w_tag, w_out_tag;
  logic          w_c, w_z, w_v, w_s, w_i;

  alu_pipe_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .opcode(n_op), .input1(n_a), .input2(n_b), .shift_amt(n_sh), .in_tag(n_tag),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result(n_res), .out_tag(n_out_tag),
    .carryFlag(n_c), .zeroFlag(n_z), .overFlowFlag(n_v), .signFlag(n_s), .illegalFlag(n_i)
  );

  alu_pipe_hs #(.WIDTH(128)) dut128 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opcode(w_op), .input1(w_a), .input2(w_b), .shift_amt(w_sh), .in_tag(w_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result(w_res), .out_tag(w_out_tag),
    .carryFlag(w_c), .zeroFlag(w_z), .overFlowFlag(w_v), .signFlag(w_s), .illegalFlag(w_i)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One transaction through the empty 8-bit pipe; flags are {carry, zero, ovf, sign, illegal}.
  task automatic run8(input string name, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [2:0] sh, input logic [3:0] tag,
                      input logic [7:0] er, input logic [4:0] ef);
    @(negedge clk);
    n_in_valid = 1'b1; n_op = op; n_a = a; n_b = b; n_sh = sh; n_tag = tag; n_out_ready = 1'b1;
    #1 chk({name, "_rdy"}, n_in_ready, 1);
    @(negedge clk);
    n_in_valid = 1'b0;
    chk({name, "_lat1"}, n_out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, n_out_valid, 1);
    chk({name, "_res"}, n_res, er);
    chk({name, "_flags"}, {n_c, n_z, n_v, n_s, n_i}, ef);
    chk({name, "_tag"}, n_out_tag, tag);
  endtask

  task automatic run128(input string name, input logic [3:0] op, input logic [127:0] a,
                        input logic [127:0] b, input logic [6:0] sh, input logic [3:0] tag,
                        input logic [127:0] er, input logic [4:0] ef);
    @(negedge clk);
    w_in_valid = 1'b1; w_op = op; w_a = a; w_b = b; w_sh = sh; w_tag = tag; w_out_ready = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    chk({name, "_lat1"}, w_out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, w_out_valid, 1);
    chk({name, "_res"}, w_res, er);
    chk({name, "_flags"}, {w_c, w_z, w_v, w_s, w_i}, ef);
    chk({name, "_tag"}, w_out_tag, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_tag, next_tag, got;
    logic saw_low, held_v;
    logic [3:0] held_tag;
    logic [7:0] held_res;

    rst = 1'b1;
    n_in_valid = 0; n_op = 0; n_a = 0; n_b = 0; n_sh = 0; n_tag = 0; n_out_ready = 1;
    w_in_valid = 0; w_op = 0; w_a = 0; w_b = 0; w_sh = 0; w_tag = 0; w_out_ready = 1;
    #12;
    chk("rst_valid", n_out_valid, 0);
    chk("rst_ready", n_in_ready, 1);
    chk("rst_res", n_res, 0);
    chk("rst_tag", n_out_tag, 0);
    chk("rst_flags", {n_c, n_z, n_v, n_s, n_i}, 0);
    chk("rst_valid128", w_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    run8("add_wrap",  4'd0,  8'hFF, 8'h01, 3'd0, 4'd3,  8'h00, 5'b11000);
    run8("add_ovf",   4'd0,  8'h7F, 8'h01, 3'd0, 4'd1,  8'h80, 5'b00110);
    run8("sub_ovf",   4'd1,  8'h80, 8'h01, 3'd0, 4'd4,  8'h7F, 5'b00100);
    run8("sub_borrow",4'd1,  8'h01, 8'h02, 3'd0, 4'd5,  8'hFF, 5'b10010);
    run8("mul8",      4'd2,  8'h10, 8'h10, 3'd0, 4'd2,  8'h00, 5'b11000);
    run8("ror0",      4'd3,  8'h81, 8'h00, 3'd0, 4'd6,  8'h81, 5'b00010);
    run8("ror1",      4'd3,  8'h01, 8'h00, 3'd1, 4'd7,  8'h80, 5'b00010);
    run8("rol1",      4'd8,  8'h81, 8'h00, 3'd1, 4'd8,  8'h03, 5'b00000);
    run8("slt",       4'd10, 8'hFF, 8'h01, 3'd0, 4'd9,  8'h01, 5'b00000);
    run8("sltu",      4'd7,  8'hFF, 8'h01, 3'd0, 4'd10, 8'h00, 5'b01000);
    run8("minu",      4'd4,  8'hFF, 8'h01, 3'd0, 4'd11, 8'h01, 5'b00000);
    run8("maxu",      4'd9,  8'hFF, 8'h01, 3'd0, 4'd12, 8'hFF, 5'b00010);
    run8("xnor",      4'd5,  8'hF0, 8'hCC, 3'd0, 4'd13, 8'hC3, 5'b00010);
    run8("nor",       4'd6,  8'hF0, 8'h0C, 3'd0, 4'd14, 8'h03, 5'b00000);
    run8("illegal",   4'd12, 8'h55, 8'h33, 3'd0, 4'd15, 8'h00, 5'b01001);

    run128("mul128", 4'd2, 128'h1 << 64, 128'h1 << 64, 7'd0, 4'd1, 128'h0, 5'b11000);
    run128("ror128", 4'd3, 128'h1, 128'h0, 7'd1, 4'd2, 128'h1 << 127, 5'b00010);
    run128("rol128", 4'd8, 128'h1 << 127, 128'h0, 7'd1, 4'd3, 128'h1, 5'b00000);

    // Backpressure: consumer stalls on loop cycles 3..6 while tags 1..6 are offered.
    exp_tag = 1; next_tag = 1; got = 0; saw_low = 0; held_v = 0;
    held_tag = '0; held_res = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      @(negedge clk);
      n_out_ready = !(cyc >= 3 && cyc <= 6);
      n_in_valid  = (next_tag <= 6);
      n_op = 4'd0; n_a = 8'(next_tag); n_b = 8'h10; n_sh = 3'd0; n_tag = 4'(next_tag);
      #1;
      if (n_out_valid && !n_out_ready) begin
        if (held_v) begin
          chk("bp_hold_tag", n_out_tag, held_tag);
          chk("bp_hold_res", n_res, held_res);
        end
        held_v = 1; held_tag = n_out_tag; held_res = n_res;
      end else begin
        held_v = 0;
      end
      if (n_in_valid && !n_in_ready) saw_low = 1;
      if (n_out_valid && n_out_ready) begin
        chk("bp_tag", n_out_tag, 4'(exp_tag));
        chk("bp_res", n_res, 8'(exp_tag + 16));
        exp_tag++;
        got++;
      end
      if (n_in_valid && n_in_ready) next_tag++;
      if (cyc == 6) chk("bp_full_accepts", 32'(next_tag), 32'd4);
    end
    n_in_valid = 1'b0;
    chk("bp_count", 32'(got), 32'd6);
    chk("bp_inready_low", saw_low, 1);
    @(negedge clk);
    @(negedge clk);
    chk("bp_drain", n_out_valid, 0);

    // Reset with two transactions in flight.
    @(negedge clk);
    n_out_ready = 1'b0; n_in_valid = 1'b1; n_op = 4'd0; n_a = 8'h11; n_b = 8'h00; n_tag = 4'd9;
    @(negedge clk);
    n_a = 8'h22; n_tag = 4'd10;
    @(negedge clk);
    n_in_valid = 1'b0;
    chk("rst_pre_valid", n_out_valid, 1);
    chk("rst_pre_res", n_res, 8'h11);
    chk("rst_pre_ready", n_in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", n_out_valid, 0);
    chk("arst_res", n_res, 0);
    chk("arst_tag", n_out_tag, 0);
    chk("arst_flags", {n_c, n_z, n_v, n_s, n_i}, 0);
    chk("arst_ready", n_in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    n_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_stale", n_out_valid, 0);
    end
    run8("post_rst", 4'd0, 8'h05, 8'h06, 3'd0, 4'd11, 8'h0B, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
